// File: rtl/ppu_pkg.sv
// ppu_pkg: types and helpers shared by the sprite fetch path.
//   fetch_phase_e : FSM state; the eight fetch states are encoded so that
//                   state[2:0] equals the PPU cycle phase they belong to.
//   SPR_FETCH_*   : first/last PPU cycle of the sprite fetch window.
//   LOAD_*        : bit layout of the 27-bit SpriteSet load word.
//   bitrev8       : 8-bit bit reversal used for horizontal flip handling.
package ppu_pkg;

    typedef enum logic [3:0] {
        PH_RD_Y    = 4'd0,
        PH_RD_TILE = 4'd1,
        PH_RD_ATTR = 4'd2,
        PH_RD_X    = 4'd3,
        PH_LO_ADDR = 4'd4,
        PH_LO_DATA = 4'd5,
        PH_HI_ADDR = 4'd6,
        PH_HI_DATA = 4'd7,
        PH_IDLE    = 4'd8
    } fetch_phase_e;

    localparam int SPR_FETCH_START = 256;
    localparam int SPR_FETCH_END   = 319;

    // MSB positions of each field in the load word
    localparam int LOAD_W       = 27;
    localparam int LOAD_LO_MSB  = 26;
    localparam int LOAD_HI_MSB  = 18;
    localparam int LOAD_X_MSB   = 10;
    localparam int LOAD_PAL_MSB = 2;

    function automatic logic [7:0] bitrev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_fetch_if.sv
// sprite_fetch_if: pattern-memory read bus between sprite_fetch and CHR memory.
//   o_vram_addr : fetch address (driven by master)
//   o_vram_rd   : one ce-cycle read strobe (driven by master)
//   i_vram_data : read data, valid one ce-cycle after the strobe (driven by slave)
interface sprite_fetch_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] o_vram_addr;
    logic              o_vram_rd;
    logic [7:0]        i_vram_data;

    modport master (
        output o_vram_addr,
        output o_vram_rd,
        input  i_vram_data
    );

    modport slave (
        input  o_vram_addr,
        input  o_vram_rd,
        output i_vram_data
    );
endinterface

// File: rtl/sprite_patt_addr.sv
// sprite_patt_addr: combinational sprite pattern address generator.
//   i_tile     : tile index byte from secondary OAM
//   i_yoff     : low 4 bits of the sprite Y offset (row inside the sprite)
//   i_vflip    : vertical flip, mirrors the row
//   i_obj_size : 1 = 8x16 sprites (table from tile[0], row[3] picks the tile half)
//   i_obj_patt : pattern table select for 8x8 sprites
//   i_plane    : 0 = low bit plane, 1 = high bit plane
//   o_addr     : 14-bit CHR address
module sprite_patt_addr (
    input  logic [7:0]  i_tile,
    input  logic [3:0]  i_yoff,
    input  logic        i_vflip,
    input  logic        i_obj_size,
    input  logic        i_obj_patt,
    input  logic        i_plane,
    output logic [13:0] o_addr
);
    logic [3:0] w_row;

    // Inverting all four bits also gives the correct 3-bit mirror for 8x8.
    assign w_row  = i_vflip ? ~i_yoff : i_yoff;

    assign o_addr = i_obj_size ?
                    {1'b0, i_tile[0], i_tile[7:1], w_row[3], i_plane, w_row[2:0]} :
                    {1'b0, i_obj_patt, i_tile, i_plane, w_row[2:0]};
endmodule

// File: rtl/sprite_fetch.sv
// sprite_fetch: sprite pattern fetch stage, PPU cycles 256-319.
// For each of the 8 secondary-OAM slots it reads Y/tile/attr/X, fetches
// both pattern planes, applies flips and emits one SpriteSet load word.
//   clk, i_rst_n  : clock, asynchronous active-low reset
//   ce            : PPU clock enable, all state advances only when high
//   i_enable      : sprite rendering enable (low aborts a running sequence)
//   i_cycle       : current PPU cycle
//   i_obj_size    : 1 = 8x16 sprites
//   i_obj_patt    : pattern table for 8x8 sprites
//   i_oam_bus     : secondary-OAM byte for the current cycle
//   vram          : pattern memory read bus (master side)
//   o_load        : 4'b1111 for one ce-cycle per slot
//   o_load_in     : {pix_lo, pix_hi, x, palette, prio}
//   o_done        : pulse together with the 8th load
module sprite_fetch
    import ppu_pkg::*;
#(
    parameter int         ADDR_W  = 14,
    parameter logic [7:0] EMPTY_Y = 8'hFF
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              ce,
    input  logic              i_enable,
    input  logic [8:0]        i_cycle,
    input  logic              i_obj_size,
    input  logic              i_obj_patt,
    input  logic [7:0]        i_oam_bus,
    sprite_fetch_if.master    vram,
    output logic [3:0]        o_load,
    output logic [LOAD_W-1:0] o_load_in,
    output logic              o_done
);
    fetch_phase_e      r_state;
    fetch_phase_e      w_cur;
    fetch_phase_e      w_state_next;
    logic [2:0]        r_slot;
    logic [7:0]        r_yoff;
    logic [7:0]        r_tile;
    logic [7:0]        r_x;
    logic [1:0]        r_pal;
    logic              r_prio;
    logic              r_hflip;
    logic              r_vflip;
    logic              r_valid;
    logic [7:0]        r_pix_lo;
    logic [ADDR_W-1:0] r_vram_addr;
    logic              r_vram_rd;
    logic [3:0]        r_load;
    logic [LOAD_W-1:0] r_load_in;
    logic              r_done;

    logic              w_in_window;
    logic              w_start;
    logic              w_abort;
    logic              w_step;
    logic [13:0]       w_patt_addr;
    logic [7:0]        w_plane_bits;
    logic [LOAD_W-1:0] w_load_word;

    assign w_in_window = (i_cycle >= 9'(SPR_FETCH_START)) && (i_cycle <= 9'(SPR_FETCH_END));
    assign w_start     = (r_state == PH_IDLE) && (i_cycle == 9'(SPR_FETCH_START)) && i_enable;

    // The register holds the phase owed to the current cycle; at cycle 256
    // IDLE is promoted to RD_Y so slot 0 byte 0 is captured that same cycle.
    assign w_cur   = w_start ? PH_RD_Y : r_state;
    assign w_abort = (w_cur != PH_IDLE) &&
                     (!i_enable || !w_in_window || (w_cur[2:0] != i_cycle[2:0]));
    assign w_step  = (w_cur != PH_IDLE) && !w_abort;

    always_comb begin
        w_state_next = PH_IDLE;
        if (w_step) begin
            if (w_cur == PH_HI_DATA) begin
                w_state_next = (r_slot == 3'd7) ? PH_IDLE : PH_RD_Y;
            end else begin
                w_state_next = fetch_phase_e'(w_cur + 4'd1);
            end
        end
    end

    // Address is registered one cycle ahead of the strobe: built in RD_X for
    // the low plane and in LO_DATA for the high plane.
    sprite_patt_addr u_patt_addr (
        .i_tile     (r_tile),
        .i_yoff     (r_yoff[3:0]),
        .i_vflip    (r_vflip),
        .i_obj_size (i_obj_size),
        .i_obj_patt (i_obj_patt),
        .i_plane    (w_cur == PH_LO_DATA),
        .o_addr     (w_patt_addr)
    );

    // SpriteSet shifts out bit 0 first, so unflipped data is reversed.
    assign w_plane_bits = !r_valid ? 8'h00 :
                          (r_hflip ? vram.i_vram_data : bitrev8(vram.i_vram_data));

    always_comb begin
        w_load_word                         = '0;
        w_load_word[LOAD_LO_MSB -: 8]       = r_pix_lo;
        w_load_word[LOAD_HI_MSB -: 8]       = w_plane_bits;
        w_load_word[LOAD_X_MSB -: 8]        = r_x;
        w_load_word[LOAD_PAL_MSB -: 2]      = r_pal;
        w_load_word[0]                      = r_prio;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= PH_IDLE;
            r_slot      <= '0;
            r_yoff      <= '0;
            r_tile      <= '0;
            r_x         <= '0;
            r_pal       <= '0;
            r_prio      <= 1'b0;
            r_hflip     <= 1'b0;
            r_vflip     <= 1'b0;
            r_valid     <= 1'b0;
            r_pix_lo    <= '0;
            r_vram_addr <= '0;
            r_vram_rd   <= 1'b0;
            r_load      <= '0;
            r_load_in   <= '0;
            r_done      <= 1'b0;
        end else if (ce) begin
            r_state   <= w_state_next;
            r_load    <= '0;
            r_done    <= 1'b0;
            r_vram_rd <= 1'b0;
            if (!w_step) begin
                r_slot <= '0;
            end else begin
                case (w_cur)
                    PH_RD_Y: begin
                        r_yoff  <= i_oam_bus;
                        r_valid <= (i_oam_bus != EMPTY_Y) &&
                                   (i_oam_bus < (i_obj_size ? 8'd16 : 8'd8));
                    end
                    PH_RD_TILE: r_tile <= i_oam_bus;
                    PH_RD_ATTR: begin
                        r_pal   <= i_oam_bus[1:0];
                        r_prio  <= i_oam_bus[5];
                        r_hflip <= i_oam_bus[6];
                        r_vflip <= i_oam_bus[7];
                    end
                    PH_RD_X: begin
                        r_x         <= i_oam_bus;
                        r_vram_addr <= ADDR_W'(w_patt_addr);
                        r_vram_rd   <= 1'b1;
                    end
                    PH_LO_DATA: begin
                        r_pix_lo    <= w_plane_bits;
                        r_vram_addr <= ADDR_W'(w_patt_addr);
                        r_vram_rd   <= 1'b1;
                    end
                    PH_HI_DATA: begin
                        r_load_in <= w_load_word;
                        r_load    <= 4'b1111;
                        r_done    <= (r_slot == 3'd7);
                        r_slot    <= r_slot + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign vram.o_vram_addr = r_vram_addr;
    // A strobe already on the bus is withdrawn in the cycle a sequence aborts.
    assign vram.o_vram_rd   = r_vram_rd && !w_abort;
    assign o_load           = r_load;
    assign o_load_in        = r_load_in;
    assign o_done           = r_done;
endmodule

// File: tb/tb_sprite_fetch.sv
module tb_sprite_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        en;
    logic [8:0]  cyc;
    logic        obj_size;
    logic        obj_patt;
    logic [7:0]  oam_bus;
    logic [3:0]  load;
    logic [26:0] load_in;
    logic        done;

    sprite_fetch_if #(.ADDR_W(14)) vif ();

    sprite_fetch #(.ADDR_W(14), .EMPTY_Y(8'hFF)) dut (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .ce         (ce),
        .i_enable   (en),
        .i_cycle    (cyc),
        .i_obj_size (obj_size),
        .i_obj_patt (obj_patt),
        .i_oam_bus  (oam_bus),
        .vram       (vif),
        .o_load     (load),
        .o_load_in  (load_in),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          line_no  = 0;
    logic [7:0]  oam [32];
    logic [7:0]  mem [16384];
    logic [26:0] exp_word = '0;
    logic        pend_rd  = 1'b0;
    logic [13:0] pend_addr = '0;
    logic [26:0] first_word;

    task automatic chk(input string tag, input int cyc_no,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s line %0d cycle %0d observed %h expected %h",
                   tag, line_no, cyc_no, obs, exp);
        end
    endtask

    function automatic int rev8(input int d);
        int r = 0;
        for (int i = 0; i < 8; i++) if ((d >> i) & 1) r = r + (1 << (7 - i));
        return r;
    endfunction

    // CHR address of slot s, plane p, straight from the address rules.
    function automatic int fetch_addr(input int s, input int p, input int size, input int patt);
        int y   = int'(oam[4*s]);
        int t   = int'(oam[4*s+1]);
        int a   = int'(oam[4*s+2]);
        int row = ((a >> 7) & 1) ? 15 - (y % 16) : (y % 16);
        if (size != 0) return (t % 2) * 4096 + (t / 2) * 32 + (row / 8) * 16 + p * 8 + (row % 8);
        return patt * 4096 + t * 16 + p * 8 + (row % 8);
    endfunction

    function automatic logic [26:0] slot_word(input int s, input int size, input int patt);
        int y = int'(oam[4*s]);
        int a = int'(oam[4*s+2]);
        int x = int'(oam[4*s+3]);
        int lo = 0, hi = 0;
        int dlo = int'(mem[fetch_addr(s, 0, size, patt)]);
        int dhi = int'(mem[fetch_addr(s, 1, size, patt)]);
        if (y != 255 && y < (size != 0 ? 16 : 8)) begin
            lo = ((a >> 6) & 1) ? dlo : rev8(dlo);
            hi = ((a >> 6) & 1) ? dhi : rev8(dhi);
        end
        return 27'(lo * 524288 + hi * 2048 + x * 8 + (a % 4) * 2 + ((a >> 5) & 1));
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 32; i++) oam[i] = 8'hFF;
    endtask

    task automatic random_oam();
        for (int s = 0; s < 8; s++) begin
            case ($urandom_range(0, 3))
                0:       oam[4*s] = 8'hFF;
                1:       oam[4*s] = 8'($urandom_range(0, 15));
                2:       oam[4*s] = 8'($urandom_range(0, 7));
                default: oam[4*s] = 8'($urandom);
            endcase
            oam[4*s+1] = 8'($urandom);
            oam[4*s+2] = 8'($urandom);
            oam[4*s+3] = 8'($urandom);
        end
    endtask

    task automatic sample(input int c, input logic exp_rd, input logic [13:0] exp_addr,
                          input logic exp_load, input logic exp_done);
        chk("vram_rd", c, 32'(vif.o_vram_rd), 32'(exp_rd));
        if (exp_rd) chk("vram_addr", c, 32'(vif.o_vram_addr), 32'(exp_addr));
        chk("load", c, 32'(load), exp_load ? 32'hF : 32'h0);
        chk("load_in", c, 32'(load_in), 32'(exp_word));
        chk("done", c, 32'(done), 32'(exp_done));
    endtask

    // One full scanline (cycles 0-340). abort_c: first cycle with i_enable low
    // (held low until 300); reset_c: cycle with an async reset pulse.
    task automatic run_line(input int size, input int patt, input int abort_c,
                            input int reset_c, input int slow, output logic [26:0] first);
        int   loads_seen = 0, loads_exp = 0, s, ph, ls;
        logic win, exp_rd, exp_load, exp_done;
        logic [13:0] exp_addr;
        first = '0;
        line_no++;
        obj_size = 1'(size);
        obj_patt = 1'(patt);
        for (int c = 0; c < 341; c++) begin
            win = (c >= 256 && c <= 319);
            s   = (c - 256) / 8;
            ph  = c % 8;
            ls  = (c - 264) / 8;
            cyc      = 9'(c);
            en       = !(c >= abort_c && c < 300);
            oam_bus  = (win && ph < 4) ? oam[4*s+ph] : 8'($urandom);
            vif.i_vram_data = pend_rd ? mem[pend_addr] : 8'($urandom);
            exp_rd   = win && (ph == 4 || ph == 6) && c < abort_c && c < reset_c;
            exp_addr = exp_rd ? 14'(fetch_addr(s, ph == 6 ? 1 : 0, size, patt)) : 14'h0;
            exp_load = (c >= 264 && c <= 320 && c % 8 == 0 && c <= abort_c && c < reset_c);
            exp_done = exp_load && ls == 7;
            if (exp_load) begin
                exp_word = slot_word(ls, size, patt);
                loads_exp++;
            end
            if (c == reset_c) begin
                exp_word = '0;
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            if (slow != 0) begin
                ce = 1'b0;
                @(negedge clk);
                sample(c, exp_rd, exp_addr, exp_load, exp_done);
                @(posedge clk); #1;
            end
            ce = 1'b1;
            @(negedge clk);
            sample(c, exp_rd, exp_addr, exp_load, exp_done);
            pend_rd   = vif.o_vram_rd;
            pend_addr = vif.o_vram_addr;
            if (load == 4'hF) begin
                if (loads_seen == 0) first = load_in;
                loads_seen++;
                $display("line %0d cycle %0d load %0d load_in %07h done %0d",
                         line_no, c, loads_seen, load_in, done);
            end
            @(posedge clk); #1;
        end
        chk("load_count", 341, loads_seen, loads_exp);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; en = 1'b1; cyc = '0;
        obj_size = 1'b0; obj_patt = 1'b0; oam_bus = '0; vif.i_vram_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_load", 0, 32'(load), 32'h0);
        chk("rst_load_in", 0, 32'(load_in), 32'h0);
        chk("rst_rd", 0, 32'(vif.o_vram_rd), 32'h0);
        chk("rst_addr", 0, 32'(vif.o_vram_addr), 32'h0);
        chk("rst_done", 0, 32'(done), 32'h0);
        rst_n = 1'b1;

        // Directed slot 0, 8x8, pattern table 0
        fill_mem(); clear_oam();
        oam[0] = 8'd3; oam[1] = 8'h42; oam[2] = 8'h01; oam[3] = 8'h84;
        mem[14'h0423] = 8'h80; mem[14'h042B] = 8'h01;
        run_line(0, 0, 1000, 1000, 0, first_word);
        chk("plan_word", 264, 32'(first_word), 32'({8'h01, 8'h80, 8'h84, 2'b01, 1'b0}));

        // Same slot with horizontal flip and priority
        oam[2] = 8'h60;
        run_line(0, 0, 1000, 1000, 0, first_word);
        chk("hflip_word", 264, 32'(first_word), 32'({8'h80, 8'h01, 8'h84, 2'b00, 1'b1}));

        // 8x16 with vertical flip
        oam[0] = 8'd12; oam[1] = 8'h43; oam[2] = 8'h80; oam[3] = 8'h10;
        run_line(1, 0, 1000, 1000, 0, first_word);

        // Randomized lines
        for (int k = 0; k < 4; k++) begin
            fill_mem(); random_oam();
            run_line(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1000, 1000, 0, first_word);
        end

        // Rendering disabled at cycle 283 (slot 3, phase 3)
        random_oam();
        run_line(0, 1, 283, 1000, 0, first_word);

        // Async reset pulse at cycle 270, then a normal line
        random_oam();
        run_line(1, 0, 1000, 270, 0, first_word);
        run_line(1, 0, 1000, 1000, 0, first_word);

        // ce every other clk, first directed scenario
        fill_mem(); clear_oam();
        oam[0] = 8'd3; oam[1] = 8'h42; oam[2] = 8'h01; oam[3] = 8'h84;
        mem[14'h0423] = 8'h80; mem[14'h042B] = 8'h01;
        run_line(0, 0, 1000, 1000, 1, first_word);
        chk("slow_word", 264, 32'(first_word), 32'({8'h01, 8'h80, 8'h84, 2'b01, 1'b0}));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
